// File: rtl/pingpong_frame_buffer.sv
// pingpong_frame_buffer: dual-bank frame buffer, camera writes one bank while the consumer reads the other
//   din_clk/rst_n      write-domain clock, async active-low reset (also resets the read domain)
//   dout_clk           read-domain clock
//   en                 global enable for writes and read-output updates
//   i_switch_pingpong  bank-select level, each toggle swaps banks
//   i_data_din(_vld)   camera pixel and its valid
//   i_conv_addr        read address (dout_clk domain)
//   o_conv_dout        registered read data, 1-cycle latency, 0 for addresses >= DEPTH
//   o_pl_buffer_ready  write bank holds a complete frame
//   o_overflow         sticky: a write was dropped because the bank was full
//   pe_clk             dout_clk / 24, 50% duty (only when PPB_PE_CLK_EN is defined)
module pingpong_frame_buffer #(
   parameter int DEPTH = 768,
   parameter int DW    = 8,
   parameter int AW    = 10
) (
   input  logic          din_clk,
   input  logic          rst_n,
   input  logic          dout_clk,
   input  logic          en,
   input  logic          i_switch_pingpong,
   input  logic [DW-1:0] i_data_din,
   input  logic          i_data_din_vld,
   input  logic [AW-1:0] i_conv_addr,
   output logic [DW-1:0] o_conv_dout,
   output logic          o_pl_buffer_ready,
`ifdef PPB_PE_CLK_EN
   output logic          o_overflow,
   output logic          pe_clk
`else
   output logic          o_overflow
`endif
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [DW-1:0] mem [0:1][0:DEPTH-1];
   logic [AW-1:0] wr_addr;
   logic          sw_q;
   logic          rd_s1;
   logic          rd_bank;
   logic          wr_bank;
   logic          tog;
   logic          wr_en;

   assign wr_bank = ~sw_q;
   assign tog     = i_switch_pingpong != sw_q;
   // a write in the toggle cycle is dropped so the new bank always starts at address 0
   assign wr_en   = en && i_data_din_vld && !o_pl_buffer_ready && !tog;

   always_ff @(posedge din_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr           <= '0;
         sw_q              <= 1'b0;
         o_pl_buffer_ready <= 1'b0;
         o_overflow        <= 1'b0;
      end else if (tog) begin
         sw_q              <= i_switch_pingpong;
         wr_addr           <= '0;
         o_pl_buffer_ready <= 1'b0;
      end else if (en && i_data_din_vld) begin
         if (o_pl_buffer_ready) begin
            o_overflow <= 1'b1;
         end else begin
            wr_addr           <= (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
            o_pl_buffer_ready <= wr_addr == LAST;
         end
      end
   end

   // memory kept free of reset so it maps onto block RAM
   always_ff @(posedge din_clk) begin
      if (wr_en) mem[wr_bank][wr_addr] <= i_data_din;
   end

   always_ff @(posedge dout_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_s1   <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         rd_s1   <= i_switch_pingpong;
         rd_bank <= rd_s1;
      end
   end

   always_ff @(posedge dout_clk or negedge rst_n) begin
      if (!rst_n) o_conv_dout <= '0;
      else if (en) o_conv_dout <= (i_conv_addr > LAST) ? '0 : mem[rd_bank][i_conv_addr];
   end

`ifdef PPB_PE_CLK_EN
   logic [3:0] pe_cnt;

   always_ff @(posedge dout_clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_cnt <= '0;
         pe_clk <= 1'b0;
      end else if (pe_cnt == 4'd11) begin
         pe_cnt <= '0;
         pe_clk <= ~pe_clk;
      end else begin
         pe_cnt <= pe_cnt + 4'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// tb_pingpong_frame_buffer: directed self-checking bench for pingpong_frame_buffer
module tb_pingpong_frame_buffer;
   logic       din_clk = 0;
   logic       dout_clk = 0;
   logic       rst_n = 0;
   logic       en = 1;
   logic       sw = 0;
   logic [7:0] din = 0;
   logic       vld = 0;
   logic [9:0] conv_addr = 0;
   logic [7:0] dout;
   logic       ready;
   logic       overflow;
`ifdef PPB_PE_CLK_EN
   logic       pe_clk;
`endif
   int total = 0;
   int bad = 0;

   always #5 din_clk = ~din_clk;
   always #7 dout_clk = ~dout_clk;

   pingpong_frame_buffer dut (
      .din_clk(din_clk),
      .rst_n(rst_n),
      .dout_clk(dout_clk),
      .en(en),
      .i_switch_pingpong(sw),
      .i_data_din(din),
      .i_data_din_vld(vld),
      .i_conv_addr(conv_addr),
      .o_conv_dout(dout),
      .o_pl_buffer_ready(ready),
`ifdef PPB_PE_CLK_EN
      .o_overflow(overflow),
      .pe_clk(pe_clk)
`else
      .o_overflow(overflow)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      @(negedge din_clk);
      din = d;
      vld = 1;
      @(posedge din_clk);
      #1;
   endtask

   task automatic idle();
      @(negedge din_clk);
      vld = 0;
   endtask

   task automatic rd(input logic [9:0] a, input logic [7:0] e, input string tag);
      @(negedge dout_clk);
      conv_addr = a;
      @(posedge dout_clk);
      #1;
      chk(tag, dout, e);
   endtask

   task automatic wait_rd(input int n);
      repeat (n) @(posedge dout_clk);
   endtask

   initial begin
      repeat (3) @(posedge din_clk);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_dout", dout, 0);
      chk("rst_wr_addr", dut.wr_addr, 0);
      @(negedge din_clk);
      rst_n = 1;

      for (int i = 0; i < 768; i++) begin
         if (i == 767) chk("ready_before_last", ready, 0);
         wr(8'(i));
      end
      idle();
      chk("fill_ready", ready, 1);
      chk("fill_wr_addr", dut.wr_addr, 0);
      chk("fill_ovf", overflow, 0);

      @(negedge din_clk);
      sw = 1;
      din = 8'hAA;
      vld = 1;
      @(posedge din_clk);
      #1;
      chk("tog_ready", ready, 0);
      chk("tog_drop_addr", dut.wr_addr, 0);
      wr(8'h55);
      idle();
      chk("after_tog_addr", dut.wr_addr, 1);

      wait_rd(4);
      rd(10'd0, 8'h00, "rd0");
      rd(10'd1, 8'h01, "rd1");
      rd(10'd767, 8'hFF, "rd767");
      rd(10'd800, 8'h00, "rd800");
      rd(10'd5, 8'h05, "rd5");

      @(negedge din_clk);
      en = 0;
      conv_addr = 10'd6;
      for (int i = 0; i < 10; i++) wr(8'hEE);
      idle();
      wait_rd(3);
      #1;
      chk("en0_wr_addr", dut.wr_addr, 1);
      chk("en0_dout_hold", dout, 8'h05);
      @(negedge din_clk);
      en = 1;

      for (int a = 1; a < 768; a++) wr(8'(a + 3));
      idle();
      chk("fill2_ready", ready, 1);
      for (int i = 0; i < 5; i++) wr(8'h77);
      idle();
      chk("ovf_set", overflow, 1);
      chk("ovf_wr_addr", dut.wr_addr, 0);
      rd(10'd0, 8'h00, "ovf_rd0");

      @(negedge din_clk);
      sw = 0;
      @(posedge din_clk);
      #1;
      chk("tog2_ready", ready, 0);
      chk("ovf_sticky", overflow, 1);
      wait_rd(4);
      rd(10'd0, 8'h55, "b0_rd0");
      rd(10'd1, 8'h04, "b0_rd1");
      rd(10'd767, 8'h02, "b0_rd767");
      rd(10'd800, 8'h00, "b0_rd800");

`ifdef PPB_PE_CLK_EN
      begin
         int r1, r2, hi;
         logic p;
         r1 = -1;
         r2 = -1;
         hi = 0;
         p = pe_clk;
         for (int k = 0; k < 80 && r2 < 0; k++) begin
            @(posedge dout_clk);
            #1;
            if (!p && pe_clk) begin
               if (r1 < 0) r1 = k;
               else r2 = k;
            end
            if (r1 >= 0 && r2 < 0 && pe_clk) hi++;
            p = pe_clk;
         end
         chk("pe_period", r2 - r1, 24);
         chk("pe_high", hi, 12);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
